// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and sizes for the MIPS memory responder.
// Loader FSM states, default memory depths and word geometry.
package mips_mem_pkg;

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_LOAD,
      ST_RELEASE,
      ST_RUN
   } state_e;

   localparam int IMEM_WORDS_DEF = 64;
   localparam int DMEM_WORDS_DEF = 64;
   localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/mips_load_assembler.sv
// mips_load_assembler: packs loader bytes into big-endian 32-bit words.
// Emits a word on the 4th byte or early on last, zero-padding low bytes.
module mips_load_assembler
   import mips_mem_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   input  logic        last_i,
   output logic        word_valid_o,
   output logic [31:0] word_o,
   output logic        word_partial_o
);

   localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] shift_q, shift_d;

   // Word assembly from buffered bytes plus the byte on the bus.
   always_comb begin
      word_valid_o   = accept_i && (last_i || cnt_q == LAST_IDX);
      word_partial_o = word_valid_o && (cnt_q != LAST_IDX);
      word_o         = '0;
      unique case (cnt_q)
         2'd0: word_o = {byte_i, 24'h0};
         2'd1: word_o = {shift_q[7:0], byte_i, 16'h0};
         2'd2: word_o = {shift_q[15:0], byte_i, 8'h0};
         2'd3: word_o = {shift_q[23:0], byte_i};
      endcase
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (clear_i || word_valid_o) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (accept_i) begin
         cnt_d   = cnt_q + 2'd1;
         shift_d = {shift_q[15:0], byte_i};
      end
   end

   // Byte counter and shift register.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: imem/dmem server for the single-cycle MIPS core.
// Loads imem byte-serially with the core held in reset, then runs it.
module mips_mem_responder
   import mips_mem_pkg::*;
#(
   parameter int IMEM_WORDS = IMEM_WORDS_DEF,
   parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        load_valid,
   input  logic [7:0]                  load_byte,
   input  logic                        load_last,
   output logic                        load_ready,
   input  logic                        load_restart,
   output logic                        core_reset_n,
   output logic [$clog2(IMEM_WORDS):0] words_loaded,
   output logic                        load_overflow,
   input  logic [31:0]                 pc,
   output logic [31:0]                 instruction,
   input  logic [31:0]                 alu_out,
   input  logic [31:0]                 write_data,
   input  logic                        mem_write,
   output logic [31:0]                 read_data
);

   localparam int K = $clog2(IMEM_WORDS);
   localparam int M = $clog2(DMEM_WORDS);
   localparam logic [K:0] FULL_CNT = (K+1)'(IMEM_WORDS);

   state_e      state_q, state_d;
   logic [K:0]  ptr_q, ptr_d;
   logic        ovf_q, ovf_d;
   logic        accept, restart, full;
   logic        word_valid, word_partial;
   logic [31:0] word;
   logic        pc_in, dm_in, dm_we;

   logic [31:0] imem [IMEM_WORDS];
   logic [31:0] dmem [DMEM_WORDS];

   assign load_ready    = (state_q == ST_HOLD) || (state_q == ST_LOAD);
   assign core_reset_n  = (state_q == ST_RUN);
   assign accept        = load_valid && load_ready;
   assign restart       = (state_q == ST_RUN) && load_restart;
   assign full          = (ptr_q == FULL_CNT);
   assign words_loaded  = ptr_q;
   assign load_overflow = ovf_q;

   mips_load_assembler u_asm (
      .clock          (clock),
      .reset          (reset),
      .clear_i        (restart),
      .accept_i       (accept),
      .byte_i         (load_byte),
      .last_i         (load_last),
      .word_valid_o   (word_valid),
      .word_o         (word),
      .word_partial_o (word_partial)
   );

   // Next state, word pointer and overflow flag.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ST_HOLD, ST_LOAD: begin
            if (accept)
               state_d = load_last ? ST_RELEASE : ST_LOAD;
         end
         ST_RELEASE: state_d = ST_RUN;
         ST_RUN: begin
            if (load_restart)
               state_d = ST_HOLD;
         end
         default: state_d = ST_HOLD;
      endcase
      if (word_valid) begin
         if (full) ovf_d = 1'b1;
         else      ptr_d = ptr_q + 1'b1;
      end
      if (restart) begin
         ptr_d = '0;
         ovf_d = 1'b0;
      end
   end

   // FSM and load bookkeeping registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_HOLD;
         ptr_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         ovf_q   <= ovf_d;
      end
   end

   // Completed loader words go to imem until it is full.
   always_ff @(posedge clock) begin
      if (!reset && word_valid && !full)
         imem[ptr_q[K-1:0]] <= word;
   end

   assign pc_in       = pc < 32'(4 * IMEM_WORDS);
   assign instruction = pc_in ? imem[pc[K+1:2]] : 32'h0;

   assign dm_in     = alu_out < 32'(4 * DMEM_WORDS);
   assign dm_we     = mem_write && dm_in && (state_q == ST_RUN);
   assign read_data = dm_in ? dmem[alu_out[M+1:2]] : 32'h0;

   // Core stores, only while running and in range.
   always_ff @(posedge clock) begin
      if (!reset && dm_we)
         dmem[alu_out[M+1:2]] <= write_data;
   end

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder: randomized checks against a word-level model.
// A second instance with a 4-word imem covers the overflow path.
module tb_mips_mem_responder;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        load_valid = 1'b0;
   logic [7:0]  load_byte = '0;
   logic        load_last = 1'b0;
   logic        load_restart = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] alu_out = '0;
   logic [31:0] write_data = '0;
   logic        mem_write = 1'b0;

   logic        load_ready, core_reset_n, load_overflow;
   logic [6:0]  words_loaded;
   logic [31:0] instruction, read_data;

   logic        s_load_ready, s_core_reset_n, s_load_overflow;
   logic [2:0]  s_words_loaded;
   logic [31:0] s_instruction, s_read_data;

   int n_checks = 0;
   int n_pass = 0;

   logic [31:0] imem_m [64];
   logic [31:0] simem_m [4];
   logic [31:0] dmem_m [64];
   bit          dmem_k [64];
   logic [7:0]  prog [$];

   always #5 clock = ~clock;

   mips_mem_responder dut (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_byte(load_byte),
      .load_last(load_last), .load_ready(load_ready),
      .load_restart(load_restart), .core_reset_n(core_reset_n),
      .words_loaded(words_loaded), .load_overflow(load_overflow),
      .pc(pc), .instruction(instruction),
      .alu_out(alu_out), .write_data(write_data),
      .mem_write(mem_write), .read_data(read_data)
   );

   mips_mem_responder #(.IMEM_WORDS(4), .DMEM_WORDS(64)) dut_s (
      .clock(clock), .reset(reset),
      .load_valid(load_valid), .load_byte(load_byte),
      .load_last(load_last), .load_ready(s_load_ready),
      .load_restart(load_restart), .core_reset_n(s_core_reset_n),
      .words_loaded(s_words_loaded), .load_overflow(s_load_overflow),
      .pc(pc), .instruction(s_instruction),
      .alu_out(alu_out), .write_data(write_data),
      .mem_write(mem_write), .read_data(s_read_data)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rst_ready", 32'(load_ready), 32'd1);
      check("rst_crn", 32'(core_reset_n), 32'd0);
      check("rst_wl", 32'(words_loaded), 32'd0);
      check("rst_ovf", 32'(load_overflow), 32'd0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic restart;
      load_restart = 1'b1;
      tick();
      load_restart = 1'b0;
   endtask

   // Send prog[], update the model, check the release timing.
   task automatic load_prog(input string tag);
      int n, nw, idx;
      logic [31:0] w;
      n  = prog.size();
      nw = (n + 3) / 4;
      for (int i = 0; i < n; i++)
         send_byte(prog[i], i == n - 1);
      check({tag, "_rel_crn"}, 32'(core_reset_n), 32'd0);
      check({tag, "_rel_rdy"}, 32'(load_ready), 32'd0);
      check({tag, "_wl"}, 32'(words_loaded), 32'(nw > 64 ? 64 : nw));
      tick();
      check({tag, "_run_crn"}, 32'(core_reset_n), 32'd1);
      for (int wi = 0; wi < nw; wi++) begin
         w = '0;
         for (int b = 0; b < 4; b++) begin
            idx = 4 * wi + b;
            w = {w[23:0], (idx < n) ? prog[idx] : 8'h00};
         end
         if (wi < 64) imem_m[wi] = w;
         if (wi < 4) simem_m[wi] = w;
      end
   endtask

   task automatic check_imem(input string tag, input int nw);
      for (int i = 0; i < nw; i++) begin
         pc = 32'(4 * i);
         #1;
         check(tag, instruction, imem_m[i]);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      bit in_r;
      int ix;
      in_r = a < 32'd256;
      ix = int'(a[7:2]);
      alu_out = a;
      write_data = d;
      mem_write = 1'b1;
      #1;
      if (!in_r) check("st_old_oob", read_data, 32'h0);
      else if (dmem_k[ix]) check("st_old", read_data, dmem_m[ix]);
      tick();
      mem_write = 1'b0;
      if (in_r) begin
         dmem_m[ix] = d;
         dmem_k[ix] = 1'b1;
      end
      check("st_new", read_data, in_r ? d : 32'h0);
   endtask

   task automatic read_chk(input logic [31:0] a);
      alu_out = a;
      #1;
      check("ld", read_data, dmem_m[a[7:2]]);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) dmem_k[i] = 1'b0;

      do_reset();

      prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
      load_prog("p8");
      pc = 32'h0; #1;
      check("p8_w0", instruction, 32'h20080005);
      pc = 32'h4; #1;
      check("p8_w1", instruction, 32'h20090007);
      pc = 32'h7; #1;
      check("pc_low_ign", instruction, 32'h20090007);
      pc = 32'h100; #1;
      check("pc_oob", instruction, 32'h0);

      send_byte(8'h55, 1'b1);
      check("run_ign_wl", 32'(words_loaded), 32'd2);
      check("run_ign_crn", 32'(core_reset_n), 32'd1);

      for (int i = 0; i < 64; i++) store(32'(4 * i), $urandom);
      store(32'h8, 32'hDEADBEEF);
      store(32'h1000, 32'h12345678);
      read_chk(32'h0);
      alu_out = 32'h1000; #1;
      check("ld_oob", read_data, 32'h0);
      for (int i = 0; i < 20; i++) begin
         if ($urandom_range(0, 1) == 1)
            store(32'($urandom_range(0, 70)) << 2, $urandom);
         else
            read_chk(32'($urandom_range(0, 63)) << 2);
      end

      alu_out = 32'h10;
      write_data = 32'hCAFE0001;
      mem_write = 1'b1;
      load_restart = 1'b1;
      tick();
      mem_write = 1'b0;
      load_restart = 1'b0;
      dmem_m[4] = 32'hCAFE0001;
      check("rs_crn", 32'(core_reset_n), 32'd0);
      check("rs_rdy", 32'(load_ready), 32'd1);
      check("rs_wl", 32'(words_loaded), 32'd0);
      read_chk(32'h10);

      alu_out = 32'h20;
      write_data = 32'h0BAD0BAD;
      mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
      read_chk(32'h20);

      prog = '{8'hAA, 8'hBB, 8'hCC};
      load_prog("p3");
      pc = 32'h0; #1;
      check("p3_w0", instruction, 32'hAABBCC00);
      pc = 32'h4; #1;
      check("p3_w1_kept", instruction, 32'h20090007);

      restart();
      prog = '{8'h11, 8'h22, 8'h33, 8'h44};
      load_prog("p1");
      check_imem("p1_im", 2);

      do_reset();
      send_byte(8'hEE, 1'b0);
      send_byte(8'hDD, 1'b0);
      do_reset();
      prog = '{8'h01, 8'h02, 8'h03, 8'h04};
      load_prog("mid");
      pc = 32'h0; #1;
      check("mid_w0", instruction, 32'h01020304);

      do_reset();
      prog = {};
      for (int i = 0; i < 20; i++) prog.push_back(8'($urandom));
      load_prog("ovf");
      check("ovf_s_wl", 32'(s_words_loaded), 32'd4);
      check("ovf_s_flag", 32'(s_load_overflow), 32'd1);
      check("ovf_s_crn", 32'(s_core_reset_n), 32'd1);
      check("ovf_m_flag", 32'(load_overflow), 32'd0);
      for (int i = 0; i < 4; i++) begin
         pc = 32'(4 * i);
         #1;
         check("ovf_s_im", s_instruction, simem_m[i]);
      end
      restart();
      check("ovf_clr", 32'(s_load_overflow), 32'd0);

      for (int r = 0; r < 6; r++) begin
         prog = {};
         for (int i = 0; i < int'($urandom_range(1, 48)); i++)
            prog.push_back(8'($urandom));
         load_prog("rnd");
         check_imem("rnd_im", (prog.size() + 3) / 4);
         for (int i = 0; i < 6; i++)
            store(32'($urandom_range(0, 63)) << 2, $urandom);
         restart();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
